axil_demux: RTL
===============

// Module: axil_demux
// PURPOSE
//  1-to-N AXI4-lite router between the CPU master port and N peripheral slaves.
//  - Decodes each address against a per-slave base/mask map.
//  - Forwards the transaction to the matching slave.
//  - Returns BRESP/RRESP, which the current flat AXI-lite bundle lacks.
//  - Unmapped addresses complete locally with DECERR.
//  - Independent read and write paths, one transaction outstanding on each.
// PARAMETERS
//  ADDR_W    32            address width
//  DATA_W    32            data width (32 or 64); strobe width = DATA_W/8
//  N_SLV     4             number of downstream slaves (1..16)
//  SLV_BASE  {N_SLV{32'h0}} packed N_SLV*ADDR_W bases; slot i = [i*ADDR_W +: ADDR_W]
//  SLV_MASK  {N_SLV{32'h0}} packed N_SLV*ADDR_W masks; hit_i = (addr & MASK_i) == BASE_i
//  TO_CYC    256           response timeout in cycles (only with AXIL_TIMEOUT_EN)
// PORTS
//  clk              in   1             clock, all logic on rising edge
//  rst              in   1             async active-high reset
//  s_aw{valid,ready,addr,prot}  in/out/in/in  1/1/ADDR_W/3   upstream write address
//  s_w{valid,ready,data,strb}   in/out/in/in  1/1/DATA_W/DATA_W/8  upstream write data
//  s_b{valid,ready,resp}        out/in/out    1/1/2          upstream write response
//  s_ar{valid,ready,addr,prot}  in/out/in/in  1/1/ADDR_W/3   upstream read address
//  s_r{valid,ready,data,resp}   out/in/out/out 1/1/DATA_W/2  upstream read data
//  m_*  same channel set, reversed directions, every field packed N_SLV wide
//       (e.g. m_awvalid N_SLV, m_awaddr N_SLV*ADDR_W); slot i drives slave i
// BEHAVIOUR
//  Reset values
//  - All *valid and *ready outputs 0; s_bresp, s_rresp, s_rdata 0.
//  - All m_* payload outputs 0; both FSMs in IDLE.
//  Decode
//  - Lowest-index hit wins. No hit -> local error path.
//  - The whole address is forwarded unmodified to the selected slot.
//  - Payload outputs of non-selected slots hold 0.
//  Write FSM
//  - W_IDLE: s_awready = s_wready = (s_awvalid & s_wvalid), combinational.
//    AW and W are accepted in the same cycle only.
//    On accept: register addr/prot/data/strb and the decoded sel.
//    Next state is W_FWD on a hit, W_ERR on a miss.
//  - W_FWD: m_awvalid[sel] and m_wvalid[sel] rise together.
//    Each drops independently after its own handshake.
//    When both are done -> W_RESP.
//  - W_RESP: m_bready[sel] = 1. On m_bvalid[sel], capture bresp -> W_BACK.
//  - W_ERR: set bresp = 2'b11 (DECERR) -> W_BACK.
//  - W_BACK: s_bvalid = 1, bresp held stable until s_bready -> W_IDLE.
//  - Minimum latency, zero-wait slave: accept cycle 0, m_awvalid cycle 1,
//    slave bvalid cycle 2, s_bvalid cycle 3.
//  Read FSM
//  - States R_IDLE / R_FWD / R_RESP / R_ERR / R_BACK, same rules as the write FSM.
//  - s_arready = s_arvalid in R_IDLE.
//  - R_ERR returns rresp = 2'b11 and rdata = 0.
//  - R_BACK holds rdata/rresp until s_rready.
//  Concurrency and handshake rules
//  - Read and write to the same or different slaves proceed concurrently.
//  - No ordering is imposed between the read and write paths.
//  - Once asserted, valid never drops before its handshake; payload stays stable.
//  - A new request is accepted only in IDLE, so the W_BACK -> W_IDLE cycle has no accept.
//  Reset mid-transaction
//  - All FSMs return to IDLE and all valids drop immediately (async).
//  - In-flight transactions are abandoned; no response is issued upstream.
// CONFIGURATION
//  AXIL_TIMEOUT_EN defined
//  - Per-path counter, cleared on entering W_FWD/R_FWD and counting while in FWD or RESP.
//  - When it reaches TO_CYC-1:
//    - drop m_*valid/ready for that slot;
//    - respond SLVERR (2'b10), with rdata = 0 on reads;
//    - go to BACK.
//  - A late slave response afterwards is ignored, because m_bready/m_rready stays 0.
//  AXIL_TIMEOUT_EN undefined
//  - No counter; the FSM waits on the slave indefinitely.
// TESTING
//  1 Map: slot0 base 0x0000_0000 mask 0xFFFF_0000; slot1 base 0x1000_0000 mask 0xFFFF_0000.
//    Write 0x1000_0004 data 0xDEADBEEF strb 0xF
//    -> only m_awvalid[1] asserts, awaddr 0x1000_0004; s_bresp 2'b00; s_bvalid at cycle 3.
//  2 Read 0x2000_0000 (unmapped)
//    -> no m_arvalid; s_rvalid with rresp 2'b11, rdata 0.
//    Same check on the write side: bresp 2'b11.
//  3 Same cycle: write to slot0, read from slot1
//    -> both complete; each response returns on its own path with correct data/resp.
//  4 Hold s_bready=0 for 5 cycles after s_bvalid
//    -> bvalid and bresp stay stable; s_awready stays 0 until the handshake.
//  5 Assert rst while W_FWD has m_awvalid[0]=1
//    -> all valids 0 the same cycle; after release, a fresh write completes normally.
//  6 AXIL_TIMEOUT_EN, TO_CYC=16, slot0 never asserts arready
//    -> s_rvalid with rresp 2'b10 at cycle 16 after accept.

Source files
------------

// File: rtl/axil_demux.sv
// axil_demux: 1-to-N AXI4-lite router with base/mask decode, local DECERR for unmapped addresses.
// Define AXIL_TIMEOUT_EN to answer SLVERR when a slave stays silent for TO_CYC cycles.
module axil_demux #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_SLV  = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
    parameter int TO_CYC = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_awvalid_i,
    output logic                       s_awready_o,
    input  logic [ADDR_W-1:0]          s_awaddr_i,
    input  logic [2:0]                 s_awprot_i,
    input  logic                       s_wvalid_i,
    output logic                       s_wready_o,
    input  logic [DATA_W-1:0]          s_wdata_i,
    input  logic [DATA_W/8-1:0]        s_wstrb_i,
    output logic                       s_bvalid_o,
    input  logic                       s_bready_i,
    output logic [1:0]                 s_bresp_o,
    input  logic                       s_arvalid_i,
    output logic                       s_arready_o,
    input  logic [ADDR_W-1:0]          s_araddr_i,
    input  logic [2:0]                 s_arprot_i,
    output logic                       s_rvalid_o,
    input  logic                       s_rready_i,
    output logic [DATA_W-1:0]          s_rdata_o,
    output logic [1:0]                 s_rresp_o,
    output logic [N_SLV-1:0]           m_awvalid_o,
    input  logic [N_SLV-1:0]           m_awready_i,
    output logic [N_SLV*ADDR_W-1:0]    m_awaddr_o,
    output logic [N_SLV*3-1:0]         m_awprot_o,
    output logic [N_SLV-1:0]           m_wvalid_o,
    input  logic [N_SLV-1:0]           m_wready_i,
    output logic [N_SLV*DATA_W-1:0]    m_wdata_o,
    output logic [N_SLV*DATA_W/8-1:0]  m_wstrb_o,
    input  logic [N_SLV-1:0]           m_bvalid_i,
    output logic [N_SLV-1:0]           m_bready_o,
    input  logic [N_SLV*2-1:0]         m_bresp_i,
    output logic [N_SLV-1:0]           m_arvalid_o,
    input  logic [N_SLV-1:0]           m_arready_i,
    output logic [N_SLV*ADDR_W-1:0]    m_araddr_o,
    output logic [N_SLV*3-1:0]         m_arprot_o,
    input  logic [N_SLV-1:0]           m_rvalid_i,
    output logic [N_SLV-1:0]           m_rready_o,
    input  logic [N_SLV*DATA_W-1:0]    m_rdata_i,
    input  logic [N_SLV*2-1:0]         m_rresp_i
);
    localparam int SELW = N_SLV > 1 ? $clog2(N_SLV) : 1;
    localparam int SW   = DATA_W / 8;

    if (N_SLV < 1 || N_SLV > 16 || TO_CYC < 2 || (DATA_W != 32 && DATA_W != 64)) begin : g_bad_params
        $error("axil_demux: unsupported parameter set");
    end

    // Returns {hit, sel}; scanning downwards lets the lowest matching slot win.
    function automatic logic [SELW:0] decode(input logic [ADDR_W-1:0] a);
        decode = '0;
        for (int i = N_SLV - 1; i >= 0; i--)
            if ((a & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
                decode = {1'b1, SELW'(i)};
    endfunction

    typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERR, W_BACK} w_state_e;
    typedef enum logic [2:0] {R_IDLE, R_FWD, R_RESP, R_ERR, R_BACK} r_state_e;

    w_state_e            w_state_q, w_state_d;
    logic                aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [SELW-1:0]     w_sel_q;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [2:0]          aw_prot_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [SW-1:0]       w_strb_q;
    logic [SELW:0]       w_dec;
    logic                w_acc, w_to;

    r_state_e            r_state_q, r_state_d;
    logic                ar_pend_q, ar_pend_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [SELW-1:0]     r_sel_q;
    logic [ADDR_W-1:0]   ar_addr_q;
    logic [2:0]          ar_prot_q;
    logic [SELW:0]       r_dec;
    logic                r_acc, r_to;

    assign w_dec       = decode(s_awaddr_i);
    assign w_acc       = (w_state_q == W_IDLE) & s_awvalid_i & s_wvalid_i;
    assign s_awready_o = w_acc;
    assign s_wready_o  = w_acc;
    assign s_bvalid_o  = w_state_q == W_BACK;
    assign s_bresp_o   = s_bvalid_o ? bresp_q : 2'b00;

    assign r_dec       = decode(s_araddr_i);
    assign r_acc       = (r_state_q == R_IDLE) & s_arvalid_i;
    assign s_arready_o = r_acc;
    assign s_rvalid_o  = r_state_q == R_BACK;
    assign s_rresp_o   = s_rvalid_o ? rresp_q : 2'b00;
    assign s_rdata_o   = s_rvalid_o ? rdata_q : '0;

`ifdef AXIL_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC) + 1;
    logic [CW-1:0] w_cnt_q, r_cnt_q;
    logic          w_busy, r_busy;
    assign w_busy = w_state_q == W_FWD || w_state_q == W_RESP;
    assign r_busy = r_state_q == R_FWD || r_state_q == R_RESP;
    // The counter value reaching TO_CYC-1 coincides with the edge that moves to BACK.
    assign w_to   = w_busy && w_cnt_q == CW'(TO_CYC - 2);
    assign r_to   = r_busy && r_cnt_q == CW'(TO_CYC - 2);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt_q <= '0;
            r_cnt_q <= '0;
        end else begin
            w_cnt_q <= w_acc ? '0 : w_busy ? w_cnt_q + 1'b1 : w_cnt_q;
            r_cnt_q <= r_acc ? '0 : r_busy ? r_cnt_q + 1'b1 : r_cnt_q;
        end
    end
`else
    assign w_to = 1'b0;
    assign r_to = 1'b0;
`endif

    always_comb begin
        w_state_d   = w_state_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        bresp_d     = bresp_q;
        m_awvalid_o = '0;
        m_awaddr_o  = '0;
        m_awprot_o  = '0;
        m_wvalid_o  = '0;
        m_wdata_o   = '0;
        m_wstrb_o   = '0;
        m_bready_o  = '0;
        if (aw_pend_q) begin
            m_awvalid_o[w_sel_q]                 = 1'b1;
            m_awaddr_o[w_sel_q*ADDR_W +: ADDR_W] = aw_addr_q;
            m_awprot_o[w_sel_q*3 +: 3]           = aw_prot_q;
        end
        if (w_pend_q) begin
            m_wvalid_o[w_sel_q]                 = 1'b1;
            m_wdata_o[w_sel_q*DATA_W +: DATA_W] = w_data_q;
            m_wstrb_o[w_sel_q*SW +: SW]         = w_strb_q;
        end
        m_bready_o[w_sel_q] = w_state_q == W_RESP;
        case (w_state_q)
            W_IDLE: if (w_acc) begin
                w_state_d = w_dec[SELW] ? W_FWD : W_ERR;
                aw_pend_d = w_dec[SELW];
                w_pend_d  = w_dec[SELW];
            end
            W_FWD: begin
                aw_pend_d = aw_pend_q & ~m_awready_i[w_sel_q];
                w_pend_d  = w_pend_q & ~m_wready_i[w_sel_q];
                if (!aw_pend_d && !w_pend_d) w_state_d = W_RESP;
            end
            W_RESP: if (m_bvalid_i[w_sel_q]) begin
                bresp_d   = m_bresp_i[w_sel_q*2 +: 2];
                w_state_d = W_BACK;
            end
            W_ERR: begin
                bresp_d   = 2'b11;
                w_state_d = W_BACK;
            end
            default: if (s_bready_i) w_state_d = W_IDLE;
        endcase
        if (w_to) begin
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
            bresp_d   = 2'b10;
            w_state_d = W_BACK;
        end
    end

    always_comb begin
        r_state_d   = r_state_q;
        ar_pend_d   = ar_pend_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        m_arvalid_o = '0;
        m_araddr_o  = '0;
        m_arprot_o  = '0;
        m_rready_o  = '0;
        if (ar_pend_q) begin
            m_arvalid_o[r_sel_q]                 = 1'b1;
            m_araddr_o[r_sel_q*ADDR_W +: ADDR_W] = ar_addr_q;
            m_arprot_o[r_sel_q*3 +: 3]           = ar_prot_q;
        end
        m_rready_o[r_sel_q] = r_state_q == R_RESP;
        case (r_state_q)
            R_IDLE: if (r_acc) begin
                r_state_d = r_dec[SELW] ? R_FWD : R_ERR;
                ar_pend_d = r_dec[SELW];
            end
            R_FWD: if (m_arready_i[r_sel_q]) begin
                ar_pend_d = 1'b0;
                r_state_d = R_RESP;
            end
            R_RESP: if (m_rvalid_i[r_sel_q]) begin
                rresp_d   = m_rresp_i[r_sel_q*2 +: 2];
                rdata_d   = m_rdata_i[r_sel_q*DATA_W +: DATA_W];
                r_state_d = R_BACK;
            end
            R_ERR: begin
                rresp_d   = 2'b11;
                rdata_d   = '0;
                r_state_d = R_BACK;
            end
            default: if (s_rready_i) r_state_d = R_IDLE;
        endcase
        if (r_to) begin
            ar_pend_d = 1'b0;
            rresp_d   = 2'b10;
            rdata_d   = '0;
            r_state_d = R_BACK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            bresp_q   <= 2'b00;
            w_sel_q   <= '0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            bresp_q   <= bresp_d;
            if (w_acc) begin
                w_sel_q   <= w_dec[SELW-1:0];
                aw_addr_q <= s_awaddr_i;
                aw_prot_q <= s_awprot_i;
                w_data_q  <= s_wdata_i;
                w_strb_q  <= s_wstrb_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            ar_pend_q <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            r_sel_q   <= '0;
            ar_addr_q <= '0;
            ar_prot_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            ar_pend_q <= ar_pend_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            if (r_acc) begin
                r_sel_q   <= r_dec[SELW-1:0];
                ar_addr_q <= s_araddr_i;
                ar_prot_q <= s_arprot_i;
            end
        end
    end
endmodule
